prog_modn_counter: RTL and testbench



---
 rtl/prog_modn_counter_pkg.sv | 16 +
 rtl/prog_modn_counter.sv | 140 ++++++++++++++
 tb/tb_prog_modn_counter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_modn_counter_pkg.sv
// Shared definitions for the programmable modulo-N counter.
// Mode encoding and direction values used by the counter and its wrappers.
// Purely declarative; no logic lives here.
package prog_modn_counter_pkg;

   typedef enum logic [1:0] {
      MODE_UP     = 2'b00,
      MODE_DOWN   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_HOLD   = 2'b11
   } mode_e;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/prog_modn_counter.sv
// Runtime-programmable modulo-N counter: up, down, bounce and hold modes.
// Latency: count/dir/wrap/mod_q update one clk edge after inputs; tc is combinational.
// Backpressure: none; en is a clock enable, and tc drives the next stage's en.
module prog_modn_counter
   import prog_modn_counter_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEFAULT_N = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mod_we,
   input  logic [WIDTH-1:0] mod_in,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] count,
   output logic             dir,
   output logic             tc,
   output logic             wrap,
   output logic [WIDTH-1:0] mod_q
);

   localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_N);
   localparam logic [WIDTH-1:0] MIN_N = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO  = '0;

   logic [WIDTH-1:0] count_nxt;
   logic             dir_nxt;
   logic             wrap_nxt;
   logic [WIDTH-1:0] mod_nxt;
   logic [WIDTH-1:0] n_new;     // requested modulus, clamped to at least 2
   logic [WIDTH-1:0] n_eff;     // modulus a same-cycle load is checked against
   logic [WIDTH-1:0] top;       // N-1, the last value of the cycle
   logic [WIDTH-1:0] top_m1;    // N-2, first value after bouncing off the top
   logic             term;      // this stage is at its terminal value for the mode

   // Next-state selection and the terminal-count output used for cascading.
   always_comb begin
      count_nxt = count;
      dir_nxt   = dir;
      wrap_nxt  = 1'b0;
      mod_nxt   = mod_q;
      n_new     = (mod_in < MIN_N) ? MIN_N : mod_in;
      n_eff     = mod_we ? n_new : mod_q;
      top       = mod_q - ONE;
      top_m1    = mod_q - MIN_N;
      term      = 1'b0;

      case (mode_e'(mode))
         MODE_UP:     term = (count == top);
         MODE_DOWN:   term = (count == ZERO);
         MODE_BOUNCE: term = (dir == DIR_UP) ? (count == top) : (count == ZERO);
         default:     term = 1'b0;
      endcase

      if (mod_we || load) begin
         // A modulus write restarts the cycle unless a load supplies the start value.
         if (mod_we) begin
            mod_nxt   = n_new;
            dir_nxt   = DIR_UP;
            count_nxt = ZERO;
         end
         if (load) begin
            count_nxt = (load_val >= n_eff) ? ZERO : load_val;
         end
      end else if (en) begin
         case (mode_e'(mode))
            MODE_UP: begin
               dir_nxt = DIR_UP;
               if (count >= top) begin
                  count_nxt = ZERO;
                  wrap_nxt  = (count == top);
               end else begin
                  count_nxt = count + ONE;
               end
            end
            MODE_DOWN: begin
               dir_nxt = DIR_DOWN;
               if (count == ZERO) begin
                  count_nxt = top;
                  wrap_nxt  = 1'b1;
               end else if (count > top) begin
                  count_nxt = top;
               end else begin
                  count_nxt = count - ONE;
               end
            end
            MODE_BOUNCE: begin
               if (dir == DIR_UP) begin
                  if (count == top) begin
                     count_nxt = top_m1;
                     dir_nxt   = DIR_DOWN;
                     wrap_nxt  = 1'b1;
                  end else if (count > top) begin
                     count_nxt = ZERO;
                  end else begin
                     count_nxt = count + ONE;
                  end
               end else begin
                  if (count == ZERO) begin
                     count_nxt = ONE;
                     dir_nxt   = DIR_UP;
                     wrap_nxt  = 1'b1;
                  end else if (count > top) begin
                     count_nxt = top;
                  end else begin
                     count_nxt = count - ONE;
                  end
               end
            end
            default: begin
               count_nxt = count;
               dir_nxt   = dir;
            end
         endcase
      end

      // Suppressed whenever this edge is not an ordinary enabled count step.
      tc = reset & en & ~load & ~mod_we & term;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= ZERO;
         dir   <= DIR_UP;
         wrap  <= 1'b0;
         mod_q <= DEF_N;
      end else begin
         count <= count_nxt;
         dir   <= dir_nxt;
         wrap  <= wrap_nxt;
         mod_q <= mod_nxt;
      end
   end

endmodule

// File: tb/tb_prog_modn_counter.sv
// Bench for prog_modn_counter: directed scenarios followed by random traffic.
// Each edge is mirrored by an integer reference model of the counter rules.
// Outputs are sampled 1 ns after the rising edge, tc just before it.
module tb_prog_modn_counter;

   localparam int WIDTH     = 8;
   localparam int DEFAULT_N = 10;

   logic             clk;
   logic             reset;
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             mod_we;
   logic [WIDTH-1:0] mod_in;
   logic [1:0]       mode;
   logic [WIDTH-1:0] count;
   logic             dir;
   logic             tc;
   logic             wrap;
   logic [WIDTH-1:0] mod_q;

   int vectors;
   int miscompares;

   // reference model state
   int m_cnt;
   int m_dir;
   int m_wrap;
   int m_mod;

   prog_modn_counter #(
      .WIDTH     (WIDTH),
      .DEFAULT_N (DEFAULT_N)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .mod_we   (mod_we),
      .mod_in   (mod_in),
      .mode     (mode),
      .count    (count),
      .dir      (dir),
      .tc       (tc),
      .wrap     (wrap),
      .mod_q    (mod_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Terminal count expected for the current inputs and model state.
   function automatic int model_tc();
      int top;
      top = m_mod - 1;
      if (!reset || load || mod_we || !en) return 0;
      case (mode)
         2'd0:    return (m_cnt == top) ? 1 : 0;
         2'd1:    return (m_cnt == 0) ? 1 : 0;
         2'd2:    return (m_dir == 0) ? ((m_cnt == top) ? 1 : 0) : ((m_cnt == 0) ? 1 : 0);
         default: return 0;
      endcase
   endfunction

   // Advance the model by one rising edge using the current inputs.
   task automatic model_edge();
      int n;
      int top;
      if (!reset) begin
         m_cnt = 0; m_dir = 0; m_wrap = 0; m_mod = DEFAULT_N;
      end else if (load || mod_we) begin
         n = m_mod;
         if (mod_we) begin
            n = (int'(mod_in) < 2) ? 2 : int'(mod_in);
            m_mod = n;
            m_dir = 0;
            m_cnt = 0;
         end
         if (load) m_cnt = (int'(load_val) >= n) ? 0 : int'(load_val);
         m_wrap = 0;
      end else if (!en || mode == 2'd3) begin
         m_wrap = 0;
      end else begin
         top = m_mod - 1;
         m_wrap = 0;
         case (mode)
            2'd0: begin
               m_wrap = (m_cnt == top) ? 1 : 0;
               m_cnt  = (m_cnt >= top) ? 0 : m_cnt + 1;
               m_dir  = 0;
            end
            2'd1: begin
               if (m_cnt == 0) begin m_cnt = top; m_wrap = 1; end
               else if (m_cnt > top) m_cnt = top;
               else m_cnt = m_cnt - 1;
               m_dir = 1;
            end
            default: begin
               if (m_dir == 0) begin
                  if (m_cnt == top) begin m_cnt = top - 1; m_dir = 1; m_wrap = 1; end
                  else if (m_cnt > top) m_cnt = 0;
                  else m_cnt = m_cnt + 1;
               end else begin
                  if (m_cnt == 0) begin m_cnt = 1; m_dir = 0; m_wrap = 1; end
                  else if (m_cnt > top) m_cnt = top;
                  else m_cnt = m_cnt - 1;
               end
            end
         endcase
      end
   endtask

   // One clock: check tc before the edge, then every registered output after it.
   task automatic step();
      #1;
      chk("tc", 32'(tc), 32'(model_tc()));
      @(posedge clk);
      model_edge();
      #1;
      chk("count", 32'(count), 32'(m_cnt));
      chk("dir",   32'(dir),   32'(m_dir));
      chk("wrap",  32'(wrap),  32'(m_wrap));
      chk("mod_q", 32'(mod_q), 32'(m_mod));
   endtask

   task automatic set_in(input logic r, input logic e, input logic ld, input int lv,
                         input logic mw, input int mi, input logic [1:0] md);
      reset = r; en = e; load = ld; load_val = WIDTH'(lv);
      mod_we = mw; mod_in = WIDTH'(mi); mode = md;
   endtask

   int up_exp[12]     = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
   int down_exp[6]    = '{4, 3, 2, 1, 0, 4};
   int bounce_exp[8]  = '{1, 2, 3, 2, 1, 0, 1, 2};
   int bounce_wrap[8] = '{0, 0, 0, 1, 0, 0, 1, 0};

   initial begin
      vectors = 0; miscompares = 0;
      m_cnt = 0; m_dir = 0; m_wrap = 0; m_mod = DEFAULT_N;

      // reset state
      set_in(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 2'd0);
      step();
      step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_mod_q", 32'(mod_q), 32'd10);

      // count up at N=10
      set_in(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 2'd0);
      for (int i = 0; i < 12; i++) begin
         if (up_exp[i] == 0) chk("up_tc_at9", 32'(tc), 32'd1);
         step();
         chk("up_seq", 32'(count), 32'(up_exp[i]));
         chk("up_wrap", 32'(wrap), (up_exp[i] == 0) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 5; i++) step();

      // modulus write while count=7, then count down at N=5
      chk("pre_mw_count", 32'(count), 32'd7);
      set_in(1'b1, 1'b1, 1'b0, 0, 1'b1, 5, 2'd0);
      step();
      chk("mw_count", 32'(count), 32'd0);
      chk("mw_mod_q", 32'(mod_q), 32'd5);
      set_in(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 2'd1);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("down_seq", 32'(count), 32'(down_exp[i]));
      end
      set_in(1'b1, 1'b0, 1'b0, 0, 1'b1, 1, 2'd1);
      step();
      chk("mw_clamp", 32'(mod_q), 32'd2);

      // bounce at N=4 from 0
      set_in(1'b1, 1'b0, 1'b0, 0, 1'b1, 4, 2'd2);
      step();
      set_in(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 2'd2);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("bounce_seq",  32'(count), 32'(bounce_exp[i]));
         chk("bounce_wrap", 32'(wrap),  32'(bounce_wrap[i]));
      end

      // parallel loads at N=10
      set_in(1'b1, 1'b0, 1'b0, 0, 1'b1, 10, 2'd0);
      step();
      set_in(1'b1, 1'b0, 1'b1, 7, 1'b0, 0, 2'd0);
      step();
      chk("load7", 32'(count), 32'd7);
      set_in(1'b1, 1'b0, 1'b1, 12, 1'b0, 0, 2'd0);
      step();
      chk("load12", 32'(count), 32'd0);
      set_in(1'b1, 1'b0, 1'b1, 5, 1'b1, 6, 2'd0);
      step();
      chk("load_mw_count", 32'(count), 32'd5);
      chk("load_mw_dir",   32'(dir),   32'd0);

      // enable toggling from 8 at N=10, then hold
      set_in(1'b1, 1'b0, 1'b1, 8, 1'b1, 10, 2'd0);
      step();
      set_in(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 2'd0);
      step();
      chk("en1_a", 32'(count), 32'd9);
      en = 1'b0;
      #1;
      chk("tc_en0", 32'(tc), 32'd0);
      step();
      chk("en0", 32'(count), 32'd9);
      en = 1'b1;
      step();
      chk("en1_b", 32'(count), 32'd0);
      mode = 2'd3;
      for (int i = 0; i < 3; i++) step();
      chk("hold", 32'(count), 32'd0);

      // reset together with load in the middle of a bounce at N=6
      set_in(1'b1, 1'b0, 1'b0, 0, 1'b1, 6, 2'd2);
      step();
      set_in(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 2'd2);
      for (int i = 0; i < 8; i++) step();
      chk("mid_count", 32'(count), 32'd2);
      chk("mid_dir",   32'(dir),   32'd1);
      set_in(1'b0, 1'b1, 1'b1, 3, 1'b0, 0, 2'd2);
      step();
      chk("rstld_count", 32'(count), 32'd0);
      chk("rstld_dir",   32'(dir),   32'd0);
      chk("rstld_mod_q", 32'(mod_q), 32'd10);
      chk("rstld_wrap",  32'(wrap),  32'd0);

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         reset    = ($urandom_range(0, 59) != 0);
         en       = ($urandom_range(0, 3) != 0);
         load     = ($urandom_range(0, 14) == 0);
         load_val = WIDTH'($urandom_range(0, 15));
         mod_we   = ($urandom_range(0, 19) == 0);
         mod_in   = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(0, 255))
                                                : WIDTH'($urandom_range(0, 12));
         mode     = 2'($urandom_range(0, 3));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
